cplx_div_seq: RTL



---
 rtl/cplx_div_seq_if.sv | 27 ++
 rtl/cplx_div_seq.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/cplx_div_seq_if.sv
// Operand/result handshake bundle for the complex divider front-end.
// slave = the sequencer side, master = the producer/consumer side.
interface cplx_div_seq_if #(
   parameter int DW = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic signed [DW-1:0] in_a;
   logic signed [DW-1:0] in_b;
   logic signed [DW-1:0] in_c;
   logic signed [DW-1:0] in_d;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [31:0]   out_re;
   logic signed [31:0]   out_im;
   logic                 out_err;

   modport slave (
      input  in_valid, in_a, in_b, in_c, in_d, out_ready,
      output in_ready, out_valid, out_re, out_im, out_err
   );

   modport master (
      output in_valid, in_a, in_b, in_c, in_d, out_ready,
      input  in_ready, out_valid, out_re, out_im, out_err
   );
endinterface

// File: rtl/cplx_div_seq.sv
// Complex divide sequencer: forms (ac+bd), (bc-ad) and c^2+d^2, then runs
// one external 32/16 sequential divider twice (real part, then imaginary part).
module cplx_div_seq #(
   parameter int DW   = 8,
   parameter int FRAC = 8
) (
   input  logic          clock,
   input  logic          reset,
   cplx_div_seq_if.slave io,
   output logic          div_start,
   output logic          div_stop,
   output logic [31:0]   div_dividend,
   output logic [15:0]   div_divisor,
   input  logic [31:0]   div_quotient
);

   localparam int PW = 2 * DW;
   localparam int NW = 2 * DW + 1;

   typedef enum logic [2:0] {
      IDLE, CALC1, CALC2, DIV_RE, CAP_RE, DIV_IM, CAP_IM, DONE
   } state_t;

   state_t               state;
   logic [5:0]           cnt;
   logic signed [DW-1:0] a_q, b_q, c_q, d_q;
   logic signed [PW-1:0] ac_q, bd_q, bc_q, ad_q, cc_q, dd_q;
   logic signed [NW-1:0] num_im_q;
   logic signed [NW-1:0] num_re_c, num_im_c;
   logic [15:0]          den_c;
   logic [31:0]          dvd_re_c, dvd_im_c;

   // Sums are formed combinationally so the zero-denominator decision and the
   // first div_start can both be issued on the CALC2 exit edge.
   always_comb begin
      num_re_c = NW'(ac_q) + NW'(bd_q);
      num_im_c = NW'(bc_q) - NW'(ad_q);
      den_c    = 16'($unsigned(cc_q)) + 16'($unsigned(dd_q));
      dvd_re_c = 32'(num_re_c) <<< FRAC;
      dvd_im_c = 32'(num_im_q) <<< FRAC;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         cnt          <= '0;
         a_q          <= '0;
         b_q          <= '0;
         c_q          <= '0;
         d_q          <= '0;
         ac_q         <= '0;
         bd_q         <= '0;
         bc_q         <= '0;
         ad_q         <= '0;
         cc_q         <= '0;
         dd_q         <= '0;
         num_im_q     <= '0;
         io.in_ready  <= 1'b1;
         io.out_valid <= 1'b0;
         io.out_re    <= '0;
         io.out_im    <= '0;
         io.out_err   <= 1'b0;
         div_start    <= 1'b0;
         div_stop     <= 1'b0;
         div_dividend <= '0;
         div_divisor  <= '0;
      end else begin
         div_start <= 1'b0;
         div_stop  <= 1'b0;
         case (state)
            IDLE: begin
               if (io.in_valid) begin
                  a_q         <= io.in_a;
                  b_q         <= io.in_b;
                  c_q         <= io.in_c;
                  d_q         <= io.in_d;
                  io.in_ready <= 1'b0;
                  io.out_err  <= 1'b0;
                  state       <= CALC1;
               end
            end
            CALC1: begin
               ac_q  <= PW'(a_q) * PW'(c_q);
               bd_q  <= PW'(b_q) * PW'(d_q);
               bc_q  <= PW'(b_q) * PW'(c_q);
               ad_q  <= PW'(a_q) * PW'(d_q);
               cc_q  <= PW'(c_q) * PW'(c_q);
               dd_q  <= PW'(d_q) * PW'(d_q);
               state <= CALC2;
            end
            CALC2: begin
               num_im_q <= num_im_c;
               if (den_c == '0) begin
                  io.out_err   <= 1'b1;
                  io.out_re    <= '0;
                  io.out_im    <= '0;
                  io.out_valid <= 1'b1;
                  state        <= DONE;
               end else begin
                  div_start    <= 1'b1;
                  div_dividend <= dvd_re_c;
                  div_divisor  <= den_c;
                  cnt          <= '0;
                  state        <= DIV_RE;
               end
            end
            DIV_RE: begin
               cnt <= cnt + 6'd1;
               if (cnt == 6'd31) div_stop <= 1'b1;
               // Stop cycle doubles as the launch of the imaginary division.
               if (cnt == 6'd32) begin
                  div_start    <= 1'b1;
                  div_dividend <= dvd_im_c;
                  cnt          <= '0;
                  state        <= CAP_RE;
               end
            end
            CAP_RE: begin
               io.out_re <= div_quotient;
               cnt       <= cnt + 6'd1;
               state     <= DIV_IM;
            end
            DIV_IM: begin
               cnt <= cnt + 6'd1;
               if (cnt == 6'd31) div_stop <= 1'b1;
               if (cnt == 6'd32) state <= CAP_IM;
            end
            CAP_IM: begin
               io.out_im    <= div_quotient;
               io.out_valid <= 1'b1;
               state        <= DONE;
            end
            DONE: begin
               if (io.out_ready) begin
                  io.out_valid <= 1'b0;
                  io.in_ready  <= 1'b1;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
